// File: rtl/harvard_pkg.sv
// harvard_pkg: shared constants and loader state encoding for the Harvard CPU system
package harvard_pkg;
    localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;
    localparam logic [31:0] NOP = 32'h0;
    typedef enum logic [2:0] {LEN, LOAD, CSUM, RUN, ERR} loader_state_t;
endpackage

// File: rtl/instr_mem_loader_if.sv
// instr_mem_loader_if: byte stream and instruction fetch signals between the loader and its environment
//   in_valid/in_data/in_ready        byte stream into the loader
//   instr_address/instr_readdata     CPU instruction fetch port
interface instr_mem_loader_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [31:0] instr_address;
    logic [31:0] instr_readdata;
    modport master (output in_valid, in_data, instr_address, input in_ready, instr_readdata);
    modport slave (input in_valid, in_data, instr_address, output in_ready, instr_readdata);
endinterface

// File: rtl/byte_word_packer.sv
// byte_word_packer: assembles accepted bytes little-endian into 32-bit words
//   clk, reset (sync, active-low), take_i (byte accepted), byte_i,
//   word_o (assembled word, valid with word_valid_o), word_valid_o (pulse on 4th byte)
module byte_word_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        take_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_valid_o
);
    logic [1:0]  cnt_q;
    logic [23:0] acc_q;
    // bytes shift in from the top, so after three bytes acc_q = {b2, b1, b0}
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
            acc_q <= '0;
        end else if (take_i) begin
            cnt_q <= cnt_q + 2'd1;
            acc_q <= {byte_i, acc_q[23:8]};
        end
    end
    assign word_o       = {byte_i, acc_q};
    assign word_valid_o = take_i && cnt_q == 2'd3;
endmodule

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: length-prefixed byte-stream program loader and instruction ROM, holds the CPU in reset until loaded
//   clk, reset (sync, active-low), clk_enable (0 freezes all state)
//   bus (instr_mem_loader_if.slave): in_valid/in_data/in_ready stream, instr_address/instr_readdata fetch
//   cpu_reset, load_done, load_error, words_loaded
// Optional: define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the data.
module instr_mem_loader
    import harvard_pkg::*;
#(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = RESET_VECTOR
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clk_enable,
    instr_mem_loader_if.slave            bus,
    output logic                         cpu_reset,
    output logic                         load_done,
    output logic                         load_error,
    output logic [$clog2(DEPTH_WORDS):0] words_loaded
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int WW = AW + 1;
    loader_state_t state_q;
    logic          len_hi_q;
    logic [7:0]    len_lo_q;
    logic [WW-1:0] n_q;
    logic [WW-1:0] words_q;
    logic          cpu_reset_q;
    logic          done_q;
    logic          err_q;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]    csum_q;
`endif
    logic [31:0]   mem [DEPTH_WORDS];
    logic          take;
    logic          word_valid;
    logic [31:0]   word;
    logic [15:0]   n_d;
    logic [31:0]   off;
    logic [AW-1:0] idx;

    assign bus.in_ready = clk_enable && (state_q == LEN || state_q == LOAD || state_q == CSUM);
    assign take         = bus.in_valid && bus.in_ready;
    assign n_d          = {bus.in_data, len_lo_q};

    byte_word_packer u_packer (
        .clk          (clk),
        .reset        (reset),
        .take_i       (take && state_q == LOAD),
        .byte_i       (bus.in_data),
        .word_o       (word),
        .word_valid_o (word_valid)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= LEN;
            len_hi_q    <= 1'b0;
            len_lo_q    <= '0;
            n_q         <= '0;
            words_q     <= '0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else if (clk_enable) begin
            case (state_q)
                LEN: if (take) begin
                    len_lo_q <= bus.in_data;
                    len_hi_q <= 1'b1;
                    if (len_hi_q) begin
                        if (n_d == 16'd0 || 32'(n_d) > 32'(DEPTH_WORDS)) begin
                            state_q <= ERR;
                            err_q   <= 1'b1;
                        end else begin
                            state_q <= LOAD;
                            n_q     <= WW'(n_d);
                        end
                    end
                end
                LOAD: if (take) begin
`ifdef LOADER_CHECKSUM_EN
                    csum_q <= csum_q ^ bus.in_data;
`endif
                    if (word_valid) begin
                        words_q <= words_q + WW'(1);
                        if (words_q + WW'(1) == n_q) begin
`ifdef LOADER_CHECKSUM_EN
                            state_q <= CSUM;
`else
                            state_q <= RUN;
                            done_q  <= 1'b1;
`endif
                        end
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                CSUM: if (take) begin
                    if (bus.in_data == csum_q) begin
                        state_q <= RUN;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= ERR;
                        err_q   <= 1'b1;
                    end
                end
`endif
                // release one enabled cycle after RUN entry so the CPU sees a reset edge
                RUN: cpu_reset_q <= 1'b0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (word_valid) mem[words_q[AW-1:0]] <= word;
    end

    // the range compare uses the full offset so addresses below BASE_ADDR wrap high and miss
    assign off                = bus.instr_address - BASE_ADDR;
    assign idx                = off[AW+1:2];
    assign bus.instr_readdata = (off < 32'(4 * DEPTH_WORDS) && WW'(idx) < words_q) ? mem[idx] : NOP;

    assign cpu_reset    = cpu_reset_q;
    assign load_done    = done_q;
    assign load_error   = err_q;
    assign words_loaded = words_q;
endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: scoreboard bench for instr_mem_loader with directed streams
module tb_instr_mem_loader;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       clk_enable = 1'b1;
    logic       cpu_reset;
    logic       load_done;
    logic       load_error;
    logic [8:0] words_loaded;
    instr_mem_loader_if bus();

    instr_mem_loader dut (
        .clk          (clk),
        .reset        (reset),
        .clk_enable   (clk_enable),
        .bus          (bus),
        .cpu_reset    (cpu_reset),
        .load_done    (load_done),
        .load_error   (load_error),
        .words_loaded (words_loaded)
    );

    typedef struct {
        bit          is_rd;
        string       name;
        logic [31:0] exp;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] mon_act;
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  csum_acc = '0;
    logic [31:0] prog [5] = '{32'h3C010001, 32'h3C030004, 32'h00231021, 32'h00000008, 32'h24000000};
    logic [31:0] w5 [2] = '{32'hDEADBEEF, 32'h01234567};

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            mon_e   = sb.pop_front();
            mon_act = mon_e.is_rd ? bus.instr_readdata
                                  : {19'b0, cpu_reset, load_done, load_error, bus.in_ready, words_loaded};
            checks++;
            if (mon_act !== mon_e.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", mon_e.name, mon_act, mon_e.exp);
            end
        end
    end

    function automatic logic [31:0] st(input logic c, input logic d, input logic e, input logic r, input logic [8:0] w);
        return {19'b0, c, d, e, r, w};
    endfunction

    task automatic check(input bit is_rd, input string name, input logic [31:0] exp);
        sb.push_back('{is_rd, name, exp});
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s: scoreboard entry not consumed, %0d left, required 0", name, sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
        bus.instr_address = addr;
        check(1'b1, name, exp);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        bus.in_valid = 1'b0;
        clk_enable = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data = b;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            errors++;
            $display("FAIL send_byte: in_ready stayed 0 for byte %h, required 1", b);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_data(input logic [7:0] b);
        csum_acc = csum_acc ^ b;
        send_byte(b);
    endtask

    task automatic send_len(input logic [15:0] n);
        csum_acc = '0;
        send_byte(n[7:0]);
        send_byte(n[15:8]);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_data(w[8*k +: 8]);
    endtask

    task automatic finish_load();
`ifdef LOADER_CHECKSUM_EN
        send_byte(csum_acc);
`endif
    endtask

    task automatic send_gappy(input logic [7:0] b, input bit data, input logic [8:0] ew);
        clk_enable = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data = b;
        check(1'b0, "frozen_no_accept", st(1, 0, 0, 0, ew));
        bus.in_valid = 1'b0;
        clk_enable = 1'b1;
        repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
        end
        if (data) send_data(b);
        else send_byte(b);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.instr_address = '0;

        // 5-word program load
        do_reset();
        check(1'b0, "reset_state", st(1, 0, 0, 1, 0));
        send_len(16'd5);
        for (int i = 0; i < 5; i++) send_word(prog[i]);
        finish_load();
        check(1'b0, "run_entry", st(1, 1, 0, 0, 5));
        check(1'b0, "cpu_release", st(0, 1, 0, 0, 5));
        rd(32'hBFC00000, 32'h3C010001, "rd_word0");
        rd(32'hBFC00008, 32'h00231021, "rd_word2");
        rd(32'hBFC0000E, 32'h00000008, "rd_word3_lowbits");
        rd(32'hBFC00010, 32'h24000000, "rd_word4");
        rd(32'hBFC00014, 32'h00000000, "rd_unloaded");
        rd(32'h00000000, 32'h00000000, "rd_addr0");
        rd(32'hBFBFFFFC, 32'h00000000, "rd_below_base");
        rd(32'hBFC00400, 32'h00000000, "rd_past_end");

        // length rejection and upper bound
        do_reset();
        send_len(16'h0000);
        check(1'b0, "len0_err", st(1, 0, 1, 0, 0));
        check(1'b0, "len0_err_hold", st(1, 0, 1, 0, 0));
        do_reset();
        send_len(16'h0101);
        check(1'b0, "len257_err", st(1, 0, 1, 0, 0));
        do_reset();
        send_len(16'h0100);
        check(1'b0, "len256_ok", st(1, 0, 0, 1, 0));

        // reset mid-load discards progress
        do_reset();
        send_len(16'd5);
        send_word(prog[0]);
        send_data(prog[1][7:0]);
        send_data(prog[1][15:8]);
        check(1'b0, "midload_status", st(1, 0, 0, 1, 1));
        rd(32'hBFC00000, 32'h3C010001, "midload_word0");
        do_reset();
        check(1'b0, "after_reset_status", st(1, 0, 0, 1, 0));
        rd(32'hBFC00000, 32'h00000000, "after_reset_rd");
        send_len(16'd2);
        send_word(32'h11223344);
        send_word(32'hAABBCCDD);
        finish_load();
        check(1'b0, "reload_run", st(1, 1, 0, 0, 2));
        rd(32'hBFC00000, 32'h11223344, "reload_word0");
        rd(32'hBFC00004, 32'hAABBCCDD, "reload_word1");

        // gaps and clock-enable freezes
        do_reset();
        csum_acc = '0;
        send_gappy(8'h02, 1'b0, 9'd0);
        send_gappy(8'h00, 1'b0, 9'd0);
        for (int i = 0; i < 8; i++) send_gappy(w5[i/4][8*(i%4) +: 8], 1'b1, 9'(i/4));
        finish_load();
        clk_enable = 1'b0;
        check(1'b0, "frozen_run_a", st(1, 1, 0, 0, 2));
        check(1'b0, "frozen_run_b", st(1, 1, 0, 0, 2));
        clk_enable = 1'b1;
        check(1'b0, "unfrozen_run", st(1, 1, 0, 0, 2));
        check(1'b0, "unfrozen_release", st(0, 1, 0, 0, 2));
        rd(32'hBFC00000, 32'hDEADBEEF, "gappy_word0");
        rd(32'hBFC00004, 32'h01234567, "gappy_word1");

`ifdef LOADER_CHECKSUM_EN
        do_reset();
        send_len(16'd1);
        send_word(32'h11223344);
        check(1'b0, "csum_wait", st(1, 0, 0, 1, 1));
        send_byte(8'h44);
        check(1'b0, "csum_good", st(1, 1, 0, 0, 1));
        do_reset();
        send_len(16'd1);
        send_word(32'h11223344);
        send_byte(8'h45);
        check(1'b0, "csum_bad", st(1, 0, 1, 0, 1));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
